mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU op this cycle.
REQ-006 SHALL have port mdu_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; all others no-op.
REQ-007 SHALL have port srcA  input  32  forwarded rs operand.
REQ-008 SHALL have port srcB  input  32  forwarded rt operand.
REQ-009 SHALL have port rd_sel  input  1  read select: 0 = LO, 1 = HI.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall_req  output  1  request to hazard controller to stall D and clear ID_EX.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.
REQ-014 SHALL have port rd_data  output  32  combinational rd_sel ? hi : lo, for mfhi/mflo.

Function
REQ-015 SHALL implement states IDLE and RUN plus a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 SHALL accept an op only when state = IDLE and start = 1; accept edge = cycle T.
REQ-017 On accepting op 1-4, SHALL latch srcA, srcB and op, load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), and enter RUN.
REQ-018 SHALL drive busy = 1 exactly in cycles T+1 .. T+N (N = loaded count), 0 otherwise.
REQ-019 In RUN, SHALL decrement cnt each edge; on the edge where cnt = 1, SHALL write HI/LO and return to IDLE, with new values visible from T+N+1.
REQ-020 mult SHALL compute a signed 64-bit product; multu unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-021 div SHALL compute signed quotient to LO and remainder to HI, truncating toward zero with remainder sign = dividend sign; divu unsigned.
REQ-022 div/divu with latched srcB = 0 SHALL still run DIV_CYCLES busy cycles and leave HI and LO unchanged.
REQ-023 div of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0.
REQ-024 mthi/mtlo accepted in IDLE SHALL write srcA to HI/LO on the accept edge with no busy cycle.
REQ-025 start = 1 while state = RUN SHALL be ignored: no latch, no HI/LO change, count unaffected.
REQ-026 stall_req SHALL equal busy OR (start AND mdu_op in 1..4), combinationally.
REQ-027 rd_data SHALL reflect HI/LO registers only, never in-flight results; mfhi/mflo during busy are prevented by stall_req.
REQ-028 mdu_op values 0 and 7-15 with start = 1 SHALL cause no state change.

Reset
REQ-029 When reset = 0 at a rising edge, SHALL set state IDLE, cnt 0, HI 0, LO 0, latched operands 0; busy, stall_req 0 from the following cycle.
REQ-030 Reset asserted during RUN SHALL abort the op; the HI/LO result is never written.
REQ-031 Reset SHALL take priority over a simultaneous start.

Verification
REQ-032 mult srcA=0xFFFFFFFE, srcB=3 at T -> busy 1 T+1..T+5; from T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-034 div srcA=-7, srcB=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-035 mthi 0x12345678 then mflo/mfhi (rd_sel 0/1) -> next cycle hi=0x12345678, rd_data follows rd_sel, busy never 1.
REQ-036 start mult while busy (cycle T+2) -> ignored, completion still at T+6 with first result; stall_req 1 throughout.
REQ-037 reset=0 at T+3 of a div -> next cycle busy 0, HI=LO=0; subsequent mult completes normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences mult/div over a fixed number of busy
// cycles, owns the HI/LO registers and raises a pipeline stall while an op is pending.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  // state | meaning
  // IDLE  | waiting for an op; mthi/mtlo complete here in one edge
  // RUN   | mult/div in flight, cnt counts remaining busy cycles
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic signed [63:0] a_ext, b_ext, prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_ovf;

  assign a_ext  = {{32{a_q[31]}}, a_q};
  assign b_ext  = {{32{b_q[31]}}, b_q};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // The most-negative / -1 quotient does not fit in 32 bits; pin it explicitly.
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign quot_s  = $signed(a_q) / $signed(b_q);
  assign rem_s   = $signed(a_q) % $signed(b_q);
  assign quot_u  = a_q / b_q;
  assign rem_u   = a_q % b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              op_d    = mdu_op;
              a_d     = srcA;
              b_d     = srcB;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = mdu_op;
              a_d     = srcA;
              b_d     = srcB;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = srcA;
            OP_MTLO: lo_d = srcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV: begin
              if (div_ovf) begin
                hi_d = 32'd0;
                lo_d = 32'h8000_0000;
              end else if (b_q != 32'd0) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign stall_req = busy | (start & (mdu_op >= OP_MULT) & (mdu_op <= OP_DIVU));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign rd_data   = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver issues ops and queues expected HI/LO plus
// busy length; a monitor pops an entry each time a busy window closes.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, rd_sel;
  logic [3:0]  mdu_op;
  logic [31:0] srcA, srcB;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rd_data;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .srcA(srcA), .srcB(srcB), .rd_sel(rd_sel),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour from the arithmetic definitions, using 64-bit integers.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit multi, output int cyc);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    multi = 1'b0;
    cyc   = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin
        multi = 1'b1; cyc = MC;
        sp = sa * sb;
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      4'd2: begin
        multi = 1'b1; cyc = MC;
        up = ua * ub;
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      4'd3: begin
        multi = 1'b1; cyc = DC;
        if (b != 32'd0) begin
          sq = sa / sb; sr = sa % sb;
          m_hi = sr[31:0]; m_lo = sq[31:0];
        end
      end
      4'd4: begin
        multi = 1'b1; cyc = DC;
        if (b != 32'd0) begin
          uq = ua / ub; ur = ua % ub;
          m_hi = ur[31:0]; m_lo = uq[31:0];
        end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    bit   multi;
    int   cyc;
    exp_t e;
    @(negedge clk);
    start = 1'b1; mdu_op = op; srcA = a; srcB = b;
    #1;
    chk({name, "_stall_at_issue"}, {31'd0, stall_req}, {31'd0, (op >= 4'd1 && op <= 4'd4)});
    model(op, a, b, multi, cyc);
    if (multi) begin
      e.hi = m_hi; e.lo = m_lo; e.cycles = cyc; e.name = name;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0; srcA = $urandom; srcB = $urandom;
    if (multi) begin
      wait_idle();
    end else begin
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_hi"}, hi, m_hi);
      chk({name, "_lo"}, lo, m_lo);
    end
    rd_sel = 1'($urandom_range(0, 1));
    #1;
    chk({name, "_rd_data"}, rd_data, rd_sel ? m_hi : m_lo);
  endtask

  // Monitor: a busy window closing is the DUT presenting a result.
  initial begin
    int   run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_busy_window", 32'(run), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_busy_len"}, 32'(run), 32'(e.cycles));
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
        run = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] specials [5];
    logic [3:0]  op;
    logic [31:0] a, b;
    int          r;
    bit          multi;
    int          cyc;
    exp_t        e;
    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'hFFFF_FFFF;
    specials[4] = 32'd7;

    reset = 1'b0; start = 1'b0; mdu_op = 4'd0; srcA = 32'd0; srcB = 32'd0; rd_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    reset = 1'b1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    chk("mult_const_hi", hi, 32'hFFFF_FFFF);
    chk("mult_const_lo", lo, 32'hFFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, "multu_const");
    chk("multu_const_hi", hi, 32'h0000_0002);
    chk("multu_const_lo", lo, 32'hFFFF_FFFA);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_const_hi", hi, 32'hFFFF_FFFF);
    chk("div_const_lo", lo, 32'hFFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0, "divu_by_zero");
    chk("divu0_hi_kept", hi, 32'hFFFF_FFFF);
    chk("divu0_lo_kept", lo, 32'hFFFF_FFFD);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    chk("div_ovf_hi", hi, 32'd0);
    chk("div_ovf_lo", lo, 32'h8000_0000);

    issue(4'd5, 32'h1234_5678, 32'd0, "mthi");
    rd_sel = 1'b0; #1;
    chk("mflo_after_mthi", rd_data, m_lo);
    rd_sel = 1'b1; #1;
    chk("mfhi_after_mthi", rd_data, 32'h1234_5678);

    // A second start while running must be dropped without disturbing the first op.
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd1; srcA = 32'd100; srcB = 32'hFFFF_FFFD;
    model(4'd1, 32'd100, 32'hFFFF_FFFD, multi, cyc);
    e.hi = m_hi; e.lo = m_lo; e.cycles = cyc; e.name = "mult_with_ignored_start";
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = 4'd2; srcA = 32'hDEAD_BEEF; srcB = 32'h0000_0F0F;
    @(negedge clk);
    chk("ignored_start_stall", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    #1;
    chk("stall_during_run", {31'd0, stall_req}, 32'd1);
    wait_idle();

    // Reset mid-divide, with a competing start on the same edge.
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; srcA = 32'd100; srcB = 32'd7;
    e.hi = 32'd0; e.lo = 32'd0; e.cycles = 3; e.name = "div_aborted";
    sbq.push_back(e);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b1; mdu_op = 4'd1; srcA = 32'd5; srcB = 32'd6;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    issue(4'd1, 32'd12345, 32'hFFFF_FF00, "mult_after_reset");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      op = 4'(r + 1);
      else if (r == 6) op = 4'd0;
      else             op = 4'($urandom_range(7, 15));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      issue(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
